// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encodings and floor constants for the elevator controller
package elevator_pkg;
  localparam int N_FLOORS = 3;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOOR = 2'd1,
    ST_MOVE = 2'd2,
    ST_HALT = 2'd3
  } state_e;
  localparam logic [N_FLOORS-1:0] FLOOR1 = 3'b001;
  localparam logic [N_FLOORS-1:0] FLOOR2 = 3'b010;
  localparam logic [N_FLOORS-1:0] FLOOR3 = 3'b100;
endpackage

// File: rtl/elevator_if.sv
// elevator_if: call/switch inputs and indicator outputs of the elevator controller
interface elevator_if;
  import elevator_pkg::*;
  logic                tick;
  logic [N_FLOORS-1:0] call;
  logic                sos;
  logic                overweight;
  logic [N_FLOORS-1:0] pending;
  logic [N_FLOORS-1:0] floor;
  logic                door_open;
  logic                moving;
  logic                dir_up;
  logic                sos_mode;
  logic                overload;
  modport master (
    output tick, call, sos, overweight,
    input  pending, floor, door_open, moving, dir_up, sos_mode, overload
  );
  modport slave (
    input  tick, call, sos, overweight,
    output pending, floor, door_open, moving, dir_up, sos_mode, overload
  );
endinterface

// File: rtl/elevator_target_sel.sv
// elevator_target_sel: SCAN direction choice from pending calls and one-hot floor
module elevator_target_sel
  import elevator_pkg::*;
(
  input  logic [N_FLOORS-1:0] pending,
  input  logic [N_FLOORS-1:0] floor,
  input  logic                dir_up,
  output logic                has_ahead,
  output logic                has_any,
  output logic                next_dir
);
  logic [N_FLOORS-1:0] below, above;
  logic                has_behind;
  always_comb begin
    below      = floor - N_FLOORS'(1);
    above      = ~(below | floor);
    has_any    = |pending;
    has_ahead  = |(pending & (dir_up ? above : below));
    has_behind = |(pending & (dir_up ? below : above));
    next_dir   = (!has_ahead && has_behind) ? ~dir_up : dir_up;
  end
endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN call scheduler with door dwell, floor travel and SOS/overweight holds
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS   = 3,
  parameter int TRAVEL_TICKS = 2,
  parameter int TICK_CNT_W   = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  elevator_if.slave bus
);
  state_e                state_q, state_d;
  logic [TICK_CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic [N_FLOORS-1:0]   pending_q, pending_d, floor_q, floor_d, call_q;
  logic [N_FLOORS-1:0]   call_edge, pend_in, nf, sel_floor;
  logic                  dir_q, dir_d, door_q, door_d, moving_q, moving_d;
  logic                  sos_q, sos_d, over_q, over_d;
  logic                  cur_edge, has_ahead, has_any, next_dir;

  assign call_edge = bus.call & ~call_q;
  assign pend_in   = pending_q | call_edge;
  assign cur_edge  = |(call_edge & floor_q);
  assign timer_inc = timer_q + TICK_CNT_W'(1);
  assign nf        = dir_q ? (floor_q == FLOOR3 ? floor_q : floor_q << 1)
                           : (floor_q == FLOOR1 ? floor_q : floor_q >> 1);
  assign sel_floor = (state_q == ST_MOVE) ? nf : floor_q;

  elevator_target_sel u_sel (
    .pending   (pending_q),
    .floor     (sel_floor),
    .dir_up    (dir_q),
    .has_ahead (has_ahead),
    .has_any   (has_any),
    .next_dir  (next_dir)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    pending_d = pend_in;
    case (state_q)
      ST_IDLE: begin
        pending_d = pend_in & ~floor_q;
        if (bus.sos) begin
          state_d   = ST_HALT;
          pending_d = '0;
          timer_d   = '0;
        end else if (cur_edge || |(pending_q & floor_q)) begin
          state_d = ST_DOOR;
          timer_d = '0;
        end else if (has_any) begin
          state_d = ST_MOVE;
          dir_d   = next_dir;
          timer_d = '0;
        end
      end
      ST_DOOR: begin
        pending_d = pend_in & ~floor_q;
        if (bus.sos) begin
          state_d   = ST_HALT;
          pending_d = '0;
          timer_d   = '0;
        end else if (bus.overweight || cur_edge) begin
          timer_d = '0;
        end else if (bus.tick) begin
          timer_d = (timer_inc == TICK_CNT_W'(DOOR_TICKS)) ? '0 : timer_inc;
          state_d = (timer_inc == TICK_CNT_W'(DOOR_TICKS)) ? ST_IDLE : ST_DOOR;
        end
      end
      ST_MOVE: begin
        if (bus.tick) begin
          timer_d = timer_inc;
          if (timer_inc == TICK_CNT_W'(TRAVEL_TICKS)) begin
            timer_d = '0;
            floor_d = nf;
            if (bus.sos) begin
              state_d   = ST_HALT;
              pending_d = '0;
            end else if (|(pend_in & nf)) begin
              state_d   = ST_DOOR;
              pending_d = pend_in & ~nf;
            end else if (!has_ahead) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_HALT: begin
        pending_d = '0;
        state_d   = bus.sos ? ST_HALT : ST_DOOR;
        timer_d   = '0;
      end
    endcase
    door_d   = (state_d == ST_DOOR) || (state_d == ST_HALT);
    moving_d = (state_d == ST_MOVE);
    sos_d    = (state_d == ST_HALT);
    over_d   = (state_d == ST_DOOR) && bus.overweight;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      floor_q   <= FLOOR1;
      call_q    <= '0;
      dir_q     <= 1'b1;
      door_q    <= 1'b0;
      moving_q  <= 1'b0;
      sos_q     <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      floor_q   <= floor_d;
      call_q    <= bus.call;
      dir_q     <= dir_d;
      door_q    <= door_d;
      moving_q  <= moving_d;
      sos_q     <= sos_d;
      over_q    <= over_d;
    end
  end

  assign bus.pending   = pending_q;
  assign bus.floor     = floor_q;
  assign bus.door_open = door_q;
  assign bus.moving    = moving_q;
  assign bus.dir_up    = dir_q;
  assign bus.sos_mode  = sos_q;
  assign bus.overload  = over_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: vector table with scoreboard queue plus async-reset sequence
module tb_elevator_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  elevator_if bus ();

  elevator_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  call;
    logic        sos;
    logic        ow;
    logic        tick;
    logic [3:0]  gap;
    logic [3:0]  rep;
    logic [10:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] sb[$];
  logic [10:0] outs;
  localparam logic [10:0] RST_OUT = 11'b000_001_0_0_1_0_0;

  assign outs = {bus.pending, bus.floor, bus.door_open, bus.moving, bus.dir_up, bus.sos_mode, bus.overload};

  function automatic vec_t v(logic [2:0] c, logic s, logic o, logic t, int g, int r, logic [10:0] e);
    vec_t x;
    x.call = c;
    x.sos  = s;
    x.ow   = o;
    x.tick = t;
    x.gap  = 4'(g);
    x.rep  = 4'(r);
    x.exp  = e;
    return x;
  endfunction

  task automatic check(string name, logic [10:0] act, logic [10:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got P/F/d/m/u/s/o=%b want=%b", name, act, want);
    end
  endtask

  task automatic run_vec(vec_t x, int idx);
    logic [10:0] e;
    for (int r = 0; r < int'(x.rep); r++) begin
      for (int g = 0; g < int'(x.gap); g++) begin
        bus.call = '0;
        bus.tick = 1'b0;
        bus.sos = x.sos;
        bus.overweight = x.ow;
        @(posedge clk);
        #1;
      end
      bus.call = x.call;
      bus.sos = x.sos;
      bus.overweight = x.ow;
      bus.tick = x.tick;
      sb.push_back(x.exp);
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      e = sb.pop_front();
      check($sformatf("vec%0d.%0d", idx, r), outs, e);
    end
  endtask

  initial begin
    bus.call = '0;
    bus.sos = 1'b0;
    bus.overweight = 1'b0;
    bus.tick = 1'b0;
    // floor 1 -> 3, ticks every 4 cycles, then dwell
    tbl.push_back(v(3'b100, 0, 0, 0, 0, 1, 11'b100_001_0_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b100_001_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 3, 1, 11'b100_001_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 3, 1, 11'b100_010_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 3, 1, 11'b100_010_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 3, 1, 11'b000_100_1_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 3, 2, 11'b000_100_1_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 3, 1, 11'b000_100_0_0_1_0_0));
    // return to floor 1 (direction reverses)
    tbl.push_back(v(3'b001, 0, 0, 0, 0, 1, 11'b001_100_0_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b001_100_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_100_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_010_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_010_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b000_001_1_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 2, 11'b000_001_1_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b000_001_0_0_0_0_0));
    // call at current floor opens door; re-press at dwell tick 2 restarts
    tbl.push_back(v(3'b001, 0, 0, 0, 0, 1, 11'b000_001_1_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 2, 11'b000_001_1_0_0_0_0));
    tbl.push_back(v(3'b001, 0, 0, 0, 0, 1, 11'b000_001_1_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 2, 11'b000_001_1_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b000_001_0_0_0_0_0));
    // go to floor 2 (ends with dir_up=1), latch 1 and 3, serve 3 then 1
    tbl.push_back(v(3'b010, 0, 0, 0, 0, 1, 11'b010_001_0_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b010_001_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b010_001_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b000_010_1_0_1_0_0));
    tbl.push_back(v(3'b101, 0, 0, 0, 0, 1, 11'b101_010_1_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 2, 11'b101_010_1_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b101_010_0_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b101_010_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b101_010_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_100_1_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 2, 11'b001_100_1_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_100_0_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b001_100_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_100_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_010_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_010_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b000_001_1_0_0_0_0));
    // overweight for 10 ticks holds the door, then 3-tick dwell
    tbl.push_back(v(3'b000, 0, 1, 1, 3, 10, 11'b000_001_1_0_0_0_1));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b000_001_1_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 2, 11'b000_001_1_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b000_001_0_0_0_0_0));
    // sos at travel tick 1: finish to floor 2, halt, ignore calls, release
    tbl.push_back(v(3'b100, 0, 0, 0, 0, 1, 11'b100_001_0_0_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b100_001_0_1_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b100_001_0_1_1_0_0));
    tbl.push_back(v(3'b000, 1, 0, 0, 0, 1, 11'b100_001_0_1_1_0_0));
    tbl.push_back(v(3'b000, 1, 0, 1, 1, 1, 11'b000_010_1_0_1_1_0));
    tbl.push_back(v(3'b001, 1, 0, 0, 0, 1, 11'b000_010_1_0_1_1_0));
    tbl.push_back(v(3'b000, 1, 0, 1, 3, 2, 11'b000_010_1_0_1_1_0));
    tbl.push_back(v(3'b010, 1, 0, 0, 0, 1, 11'b000_010_1_0_1_1_0));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b000_010_1_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 2, 11'b000_010_1_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b000_010_0_0_1_0_0));
    // start travel 2 -> 1 for the async reset sequence
    tbl.push_back(v(3'b001, 0, 0, 0, 0, 1, 11'b001_010_0_0_1_0_0));
    tbl.push_back(v(3'b000, 0, 0, 0, 0, 1, 11'b001_010_0_1_0_0_0));
    tbl.push_back(v(3'b000, 0, 0, 1, 1, 1, 11'b001_010_0_1_0_0_0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", outs, RST_OUT);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", outs, RST_OUT);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs, RST_OUT);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("after_async_reset", outs, RST_OUT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
